// File: rtl/user_if_sequencer.sv
// Command sequencer behind a Nios slave user interface: latches a command word,
// snapshots 16 operand words and runs COPY/SUM/MAX/CLEAR one word per cycle.
module user_if_sequencer (
    input  logic         clk_clk,
    input  logic         reset_reset,
    input  logic [511:0] user_dataout,
    input  logic         user_write,
    input  logic         user_chipselect,
    output logic [511:0] user_datain,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_RUN,
        S_POST
    } state_t;

    localparam logic [3:0] OP_COPY  = 4'd0;
    localparam logic [3:0] OP_SUM   = 4'd1;
    localparam logic [3:0] OP_MAX   = 4'd2;
    localparam logic [3:0] OP_CLEAR = 4'd3;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  n_q, n_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] aux_q, aux_d;
    logic [31:0] shadow_q [16];
    logic [31:0] shadow_d [16];
    logic [31:0] res_q [16];
    logic [31:0] res_d [16];
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dsticky_q, dsticky_d;
    logic        err_q, err_d;
    logic        ovr_q, ovr_d;
    logic        abt_q, abt_d;

    logic        strobe;
    logic [31:0] cmd;
    logic [3:0]  cmd_op;
    logic [3:0]  cmd_n;
    logic        cmd_go;
    logic        cmd_abort;
    logic        cmd_valid;
    logic [31:0] cur_word;
    logic [32:0] sum_w;

    always_comb begin
        strobe    = user_write & user_chipselect;
        cmd       = user_dataout[31:0];
        cmd_go    = cmd[0];
        cmd_abort = cmd[1];
        cmd_op    = cmd[7:4];
        cmd_n     = cmd[11:8];
        cmd_valid = (cmd_op <= OP_CLEAR) && ((cmd_n != 4'd0) || (cmd_op == OP_CLEAR));
        cur_word  = shadow_q[idx_q];
        sum_w     = {1'b0, acc_q} + {1'b0, cur_word};

        state_d   = state_q;
        idx_d     = idx_q;
        op_d      = op_q;
        n_d       = n_q;
        acc_d     = acc_q;
        aux_d     = aux_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dsticky_d = dsticky_q;
        err_d     = err_q;
        ovr_d     = ovr_q;
        abt_d     = abt_q;
        for (int unsigned i = 0; i < 16; i++) begin
            shadow_d[i] = shadow_q[i];
            res_d[i]    = res_q[i];
        end

        unique case (state_q)
            S_IDLE: begin
                if (strobe && cmd_go) begin
                    op_d      = cmd_op;
                    n_d       = cmd_n;
                    busy_d    = 1'b1;
                    dsticky_d = 1'b0;
                    abt_d     = 1'b0;
                    if (cmd_valid) begin
                        err_d   = 1'b0;
                        if (cmd[3]) begin
                            ovr_d = 1'b0;
                        end
                        state_d = S_LATCH;
                    end else begin
                        // Invalid commands skip straight to POST so done pulses one edge later.
                        err_d   = 1'b1;
                        state_d = S_POST;
                    end
                end
            end

            S_LATCH, S_RUN: begin
                if (strobe && cmd_abort) begin
                    abt_d   = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    if (strobe) begin
                        ovr_d = 1'b1;
                    end
                    if (state_q == S_LATCH) begin
                        for (int unsigned i = 0; i < 16; i++) begin
                            shadow_d[i] = user_dataout[32*i +: 32];
                        end
                        idx_d   = 4'd1;
                        acc_d   = '0;
                        aux_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        case (op_q)
                            OP_SUM: begin
                                acc_d = sum_w[31:0];
                                aux_d = aux_q + {31'b0, sum_w[32]};
                            end
                            OP_MAX: begin
                                // Strict compare keeps the lowest index on ties.
                                if ((idx_q == 4'd1) || (cur_word > acc_q)) begin
                                    acc_d = cur_word;
                                    aux_d = {28'b0, idx_q};
                                end
                            end
                            default: ;
                        endcase
                        if ((op_q == OP_CLEAR) || (idx_q == n_q)) begin
                            state_d = S_POST;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                end
            end

            S_POST: begin
                if (strobe && cmd_go) begin
                    ovr_d = 1'b1;
                end
                busy_d    = 1'b0;
                done_d    = 1'b1;
                dsticky_d = 1'b1;
                idx_d     = '0;
                state_d   = S_IDLE;
                if (!err_q) begin
                    case (op_q)
                        OP_COPY: begin
                            for (int unsigned i = 1; i < 16; i++) begin
                                if (i <= 32'(n_q)) begin
                                    res_d[i] = shadow_q[i];
                                end
                            end
                        end
                        OP_SUM, OP_MAX: begin
                            res_d[1] = acc_q;
                            res_d[2] = aux_q;
                        end
                        OP_CLEAR: begin
                            for (int unsigned i = 1; i < 16; i++) begin
                                res_d[i] = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            default: state_d = S_IDLE;
        endcase

        res_d[0] = {16'b0, n_d, op_d, 3'b0, abt_d, ovr_d, err_d, dsticky_d, busy_d};
    end

    always_ff @(posedge clk_clk or negedge reset_reset) begin
        if (!reset_reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            op_q      <= '0;
            n_q       <= '0;
            acc_q     <= '0;
            aux_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dsticky_q <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
            abt_q     <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                shadow_q[i] <= '0;
                res_q[i]    <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            op_q      <= op_d;
            n_q       <= n_d;
            acc_q     <= acc_d;
            aux_q     <= aux_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dsticky_q <= dsticky_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
            abt_q     <= abt_d;
            for (int unsigned i = 0; i < 16; i++) begin
                shadow_q[i] <= shadow_d[i];
                res_q[i]    <= res_d[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            user_datain[32*i +: 32] = res_q[i];
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/user_if_sequencer.md
USER_IF_SEQUENCER -- requirements
Module: user_if_sequencer

Interface
REQ-001 clk_clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 reset_reset  in  1  asynchronous, active-low reset.
REQ-003 user_dataout  in  512  16 Nios-written words; word i at [32i+31:32i].
REQ-004 user_write  in  1  one-cycle Nios write strobe from the slave user interface.
REQ-005 user_chipselect  in  1  slave chipselect; a strobe is user_write & user_chipselect.
REQ-006 user_datain  out  512  16 Nios-readable words; word 0 is status; words 1..15 are results.
REQ-007 busy  out  1  high from command acceptance until completion.
REQ-008 done  out  1  one-cycle completion pulse.

Function
REQ-009 Command word (word 0 of user_dataout) fields: bit0 GO, bit1 ABORT, [7:4] opcode, [11:8] N (operand count, words 1..N).
REQ-010 States: IDLE, LATCH, RUN, POST; register index idx 4 bits.
REQ-011 IDLE: strobe with GO=1 and a valid command -> LATCH, busy=1, sticky done/error/aborted cleared; strobe with GO=0 is ignored.
REQ-012 LATCH: snapshot all 16 input words into shadow registers; idx=1; -> RUN.
REQ-013 RUN: process shadow[idx] one word per cycle; after idx==N -> POST.
REQ-014 POST: write results to user_datain, done=1 for exactly one cycle, busy=0, -> IDLE.
REQ-015 Latency: strobe sampled at edge 0 -> done and results visible after edge N+2; busy high after edges 0..N+1.
REQ-016 Opcode 0 COPY: datain[i]=shadow[i] for i=1..N; other words unchanged.
REQ-017 Opcode 1 SUM: datain[1]=32-bit wrapping sum of words 1..N; datain[2]=count of carry-outs; words 3..15 unchanged.
REQ-018 Opcode 2 MAX: datain[1]=unsigned maximum of words 1..N; datain[2]=lowest index holding it.
REQ-019 Opcode 3 CLEAR: datain[1..15]=0; N ignored, RUN lasts one cycle (done after edge 3).
REQ-020 Invalid command (opcode>3, or N=0 with opcode 0..2): error=1, no LATCH/RUN, done pulse after edge 1, datain[1..15] unchanged.
REQ-021 Strobe while busy with ABORT=1 in LATCH or RUN: -> IDLE next edge, aborted=1, busy=0, no done pulse, datain[1..15] unchanged.
REQ-022 Strobe while busy with ABORT=0: ignored, overrun sticky=1.
REQ-023 Strobe in POST: POST completes normally; ABORT ignored; overrun=1 if GO=1.
REQ-024 Status word datain[0]: bit0 busy, bit1 done-sticky, bit2 error, bit3 overrun, bit4 aborted, [11:8] last opcode, [15:12] last N, others 0.
REQ-025 Overrun clears only on reset or an accepted command whose word 0 has bit3 set.
REQ-026 user_datain words are registered; no combinational path from inputs to outputs.

Reset
REQ-027 Reset asserted: state IDLE, idx 0, shadows 0, user_datain all 0, busy 0, done 0, all sticky flags 0, immediately and asynchronously.
REQ-028 Reset mid-operation aborts without done pulse; deassertion resumes in IDLE with no pending command.

Verification
REQ-029 SUM N=3, words 1..3 = 0xFFFFFFFF,2,3: strobe at edge 0 -> done after edge 5, datain[1]=0x00000004, datain[2]=1, status bit1=1.
REQ-030 MAX N=4, words 5,9,9,1 -> datain[1]=9, datain[2]=2; COPY N=2 -> words 1..2 mirrored, word 3 unchanged.
REQ-031 Opcode 5 -> error=1, done after edge 1, datain[1..15] unchanged, busy never rises past edge 1.
REQ-032 COPY N=15, second GO strobe during RUN -> overrun=1, first command completes after edge 17; ABORT strobe during RUN instead -> IDLE, aborted=1, no done.
REQ-033 reset_reset low during RUN of SUM N=8 -> all outputs 0 immediately; after release, new CLEAR command completes after edge 3.
REQ-034 Strobe with user_chipselect=0 or GO=0 in IDLE -> no state change, busy stays 0.
